// File: rtl/ram_word_master.sv
// Word/half/byte access master that sequences a synchronous 8-bit RAM one byte per cycle.
// Optional alignment checking is enabled by defining RAM_WORD_MASTER_ALIGN_CHECK_EN.
module ram_word_master #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              ram_r_wn,
   output logic [ADDR_W-1:0] ram_address,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, DONE} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       wdata_q;
   logic [31:0]       buf_q;
   logic [31:0]       assembled;
   logic [31:0]       extended;
   logic [1:0]        size_q;
   logic [1:0]        idx;
   logic [1:0]        last_idx;
   logic              unsigned_q;
   logic              err_q;
   logic              accept;
   logic              misaligned;

   assign accept = req && (state == IDLE || state == DONE);

`ifdef RAM_WORD_MASTER_ALIGN_CHECK_EN
   assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      last_idx = 2'd3;
      case (size_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               if (misaligned)
                  state_n = DONE;
               else if (we)
                  state_n = WRITE;
               else
                  state_n = READ;
            end else begin
               state_n = IDLE;
            end
         end
         WRITE:   if (idx == last_idx) state_n = DONE;
         READ:    if (idx == last_idx) state_n = CAPTURE;
         CAPTURE: state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   // The RAM output lags its address by one edge, so READ stores the byte requested in the previous cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         base_q     <= '0;
         wdata_q    <= '0;
         buf_q      <= '0;
         size_q     <= '0;
         idx        <= '0;
         unsigned_q <= 1'b0;
         err_q      <= 1'b0;
         rdata      <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  base_q     <= addr;
                  wdata_q    <= wdata;
                  size_q     <= size;
                  unsigned_q <= unsigned_ld;
                  idx        <= '0;
                  buf_q      <= '0;
                  err_q      <= misaligned;
               end
            end
            WRITE: begin
               if (idx != last_idx) idx <= idx + 2'd1;
            end
            READ: begin
               if (idx != 2'd0) buf_q[{idx - 2'd1, 3'b000} +: 8] <= ram_rdata;
               if (idx != last_idx) idx <= idx + 2'd1;
            end
            CAPTURE: rdata <= extended;
            default: ;
         endcase
      end
   end

   always_comb begin
      assembled = buf_q;
      assembled[{last_idx, 3'b000} +: 8] = ram_rdata;
   end

   always_comb begin
      extended = assembled;
      case (size_q)
         2'b00:   extended = unsigned_q ? {24'h0, assembled[7:0]}
                                        : {{24{assembled[7]}}, assembled[7:0]};
         2'b01:   extended = unsigned_q ? {16'h0, assembled[15:0]}
                                        : {{16{assembled[15]}}, assembled[15:0]};
         default: extended = assembled;
      endcase
   end

   assign busy = (state == WRITE) || (state == READ) || (state == CAPTURE);
   assign done = (state == DONE);
   assign err  = done && err_q;

   // Reset forces a read immediately so an aborted store cannot commit one more byte on the reset edge.
   assign ram_r_wn    = rst || (state != WRITE);
   assign ram_address = (state == WRITE || state == READ) ? base_q + ADDR_W'(idx) : '0;
   assign ram_wdata   = (state == WRITE) ? wdata_q[{idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: doc/ram_word_master.md
RAM_WORD_MASTER -- requirements
Module: ram_word_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the byte-address width of the attached byte RAM (4096 bytes at default).
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1: CPU access request, sampled only when busy=0.
REQ-005 SHALL have port we, input, 1: 1=store, 0=load.
REQ-006 SHALL have port size, input, 2: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL have port unsigned_ld, input, 1: 1=zero-extend, 0=sign-extend byte/half loads.
REQ-008 SHALL have port addr, input, ADDR_W: base byte address.
REQ-009 SHALL have port wdata, input, 32: store data, little-endian, low bytes used for byte/half.
REQ-010 SHALL have port busy, output, 1: access in progress, req ignored.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: one-cycle misalignment flag, coincident with done.
REQ-013 SHALL have port rdata, output, 32: extended load result.
REQ-014 SHALL have port ram_r_wn, output, 1: to RAM r_wn; 1=read, 0=write on the next edge.
REQ-015 SHALL have port ram_address, output, ADDR_W: to RAM address.
REQ-016 SHALL have port ram_wdata, output, 8: to RAM data_in.
REQ-017 SHALL have port ram_rdata, input, 8: from RAM data_out, valid one edge after address presented with ram_r_wn=1.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, CAPTURE, DONE; request accepted in IDLE or DONE when req=1 (edge E0); N = 1/2/4 bytes per size.
REQ-019 SHALL, in WRITE, drive ram_r_wn=0, ram_address=addr+i, ram_wdata=wdata[8i+7:8i] for i=0..N-1 in consecutive cycles, so RAM commits at edges E1..EN.
REQ-020 SHALL, in READ, drive ram_r_wn=1, ram_address=addr+i for i=0..N-1 in consecutive cycles, capturing ram_rdata into byte i one edge later; CAPTURE takes the final byte at edge EN+1.
REQ-021 SHALL assert done for exactly one cycle: after edge EN for stores, after edge EN+1 for loads (state DONE).
REQ-022 SHALL update rdata at the DONE transition of loads only: byte/half sign- or zero-extended to 32 bits per unsigned_ld; rdata held otherwise.
REQ-023 SHALL hold busy=1 in WRITE, READ, CAPTURE; busy=0 in IDLE and DONE, permitting back-to-back acceptance in the DONE cycle.
REQ-024 SHALL drive ram_r_wn=1 in every state except WRITE, so no RAM byte is written outside a store.
REQ-025 SHALL compute byte addresses modulo 2^ADDR_W (wrap-around from max to 0).
REQ-026 SHALL ignore req, we, size, addr, wdata, unsigned_ld while busy=1; operands latched at E0.

Reset
REQ-027 SHALL, on rst=1 at an edge, enter IDLE and set busy=0, done=0, err=0, rdata=0, ram_r_wn=1, ram_address=0, ram_wdata=0.
REQ-028 SHALL abort any in-flight access on reset; bytes already committed remain in RAM, done not asserted for the aborted access.

Configuration
REQ-029 SHALL, with macro RAM_WORD_MASTER_ALIGN_CHECK_EN defined, treat half at odd address or word at address not multiple of 4 as misaligned: no RAM cycle, ram_r_wn stays 1, done=1 and err=1 one cycle after E0, rdata unchanged.
REQ-030 SHALL, without RAM_WORD_MASTER_ALIGN_CHECK_EN, never assert err and perform misaligned accesses bytewise per REQ-019/020 with wrap per REQ-025.

Verification
REQ-031 SHALL cover: store word 0xDEADBEEF at 0x010 -> RAM 0x010..0x013 = EF,BE,AD,DE; done 4 edges after E0; then load word 0x010 -> rdata=0xDEADBEEF, done 5 edges after E0.
REQ-032 SHALL cover: RAM 0x020=0x80, load byte signed -> rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 SHALL cover: store half 0x1234 at 0x030, req held high through busy -> exactly one store, 0x030=34, 0x031=12, 0x032 untouched.
REQ-034 SHALL cover: load word at 0x002 -> with ALIGN_CHECK_EN done=err=1 one cycle after E0, no RAM access; without, bytes 0x002..0x005 assembled, err=0.
REQ-035 SHALL cover: without ALIGN_CHECK_EN, store word 0x11223344 at 0xFFE -> 0xFFE=44, 0xFFF=33, 0x000=22, 0x001=11.
REQ-036 SHALL cover: rst asserted after second byte of word store at 0x040 -> 0x040,0x041 written, 0x042/0x043 unchanged, ram_r_wn=1 next cycle, no done.
